ssbcc_outport_uart_tx: RTL and testbench

//   Consumer end of the 9x8 core's output-port interface: buffers bytes the core

---
 rtl/ssbcc_uart_pkg.sv | 23 ++
 rtl/ssbcc_sync_fifo.sv | 68 ++++++
 rtl/ssbcc_outport_uart_tx.sv | 155 +++++++++++++++
 tb/tb_ssbcc_outport_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssbcc_uart_pkg.sv
// Shared definitions for the 9x8 core UART transmitter outport:
// FSM encoding, frame constants and a constant-evaluable clog2.
package ssbcc_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  // Wide enough to index the data bits and the (at most two) stop bits.
  localparam int BIT_IDX_W = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ssbcc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags
// derived from an occupancy count; a write while full succeeds only with a pop.
module ssbcc_sync_fifo
  import ssbcc_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd_en);

  always_comb begin
    // NOTE: assign a default first so every path drives count_next and no latch is inferred.
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == COUNT_FULL);
      empty <= (count_next == '0);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ssbcc_outport_uart_tx.sv
// Outport consumer for the 9x8 core: queues written bytes and sends them as
// 8N1/8N2 UART frames, back to back while bytes remain, with status for an inport.
module ssbcc_outport_uart_tx
  import ssbcc_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int NSTOP      = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_out_data,
  input  logic       i_out_wr,
  input  logic       i_ovf_clr,
  output logic       o_uart_tx,
  output logic       o_fifo_full,
  output logic       o_fifo_empty,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int BW = clog2(BAUD_DIV);
  localparam logic [BW-1:0]        BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_STOP = BIT_IDX_W'(NSTOP - 1);

  uart_state_e          state, state_next;
  logic [BW-1:0]        baud_cnt, baud_next;
  logic [BIT_IDX_W-1:0] bit_idx, bit_next;
  logic [7:0]           shift, shift_next;
  logic                 tx_q, tx_next;
  logic                 ovf_q;
  logic                 pop;
  logic                 tick;
  logic                 drop;
  logic [7:0]           fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  ssbcc_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .wr      (i_out_wr),
    .wr_data (i_out_data),
    .rd      (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tick = (baud_cnt == '0);
  // A write into a full FIFO is only lost if the transmitter is not popping this cycle.
  assign drop = i_out_wr && fifo_full && !pop;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx_q     <= tx_next;
      if (drop)           ovf_q <= 1'b1;
      else if (i_ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_rd_data;
          baud_next  = BAUD_LAST;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          baud_next  = BAUD_LAST;
          bit_next   = '0;
          state_next = ST_DATA;
        end else begin
          baud_next = baud_cnt - BW'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          baud_next = BAUD_LAST;
          if (bit_idx == LAST_DATA) begin
            bit_next   = '0;
            state_next = ST_STOP;
          end else begin
            bit_next   = bit_idx + BIT_IDX_W'(1);
            shift_next = shift >> 1;
          end
        end else begin
          baud_next = baud_cnt - BW'(1);
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_idx != LAST_STOP) begin
            bit_next  = bit_idx + BIT_IDX_W'(1);
            baud_next = BAUD_LAST;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit so frames stay contiguous.
            pop        = 1'b1;
            shift_next = fifo_rd_data;
            bit_next   = '0;
            baud_next  = BAUD_LAST;
            state_next = ST_START;
          end else begin
            bit_next   = '0;
            state_next = ST_IDLE;
          end
        end else begin
          baud_next = baud_cnt - BW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The line level is computed from the next state so the flop output lines up with the state.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[0];
      default:  tx_next = 1'b1;
    endcase
    o_busy = (state != ST_IDLE) || !fifo_empty;
  end

  assign o_uart_tx    = tx_q;
  assign o_fifo_full  = fifo_full;
  assign o_fifo_empty = fifo_empty;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_ssbcc_outport_uart_tx.sv
// Scoreboard bench for ssbcc_outport_uart_tx: accepted bytes are queued on write
// and compared against frames decoded cycle by cycle from the serial line.
module tb_ssbcc_outport_uart_tx;

  localparam int BD = 4;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data1 = '0, data2 = '0;
  logic       wr1 = 1'b0, wr2 = 1'b0, ovf_clr = 1'b0;
  logic       tx1, full1, empty1, busy1, ovf1;
  logic       tx2, full2, empty2, busy2, ovf2;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         last_start = 0;
  int         t0;
  int         lows;
  logic [7:0] sb [$];

  logic [7:0] t3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] t4 [6] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};

  ssbcc_outport_uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(FD), .NSTOP(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_out_data(data1), .i_out_wr(wr1), .i_ovf_clr(ovf_clr),
    .o_uart_tx(tx1), .o_fifo_full(full1), .o_fifo_empty(empty1), .o_busy(busy1),
    .o_overflow(ovf1)
  );

  ssbcc_outport_uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(FD), .NSTOP(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_out_data(data2), .i_out_wr(wr2), .i_ovf_clr(ovf_clr),
    .o_uart_tx(tx2), .o_fifo_full(full2), .o_fifo_empty(empty2), .o_busy(busy2),
    .o_overflow(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx2 : tx1;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy2 : busy1;
  endfunction

  // Drives one write cycle; called at posedge+1, returns at the next posedge+1.
  task automatic wr_byte(input bit sel, input logic [7:0] b, input bit accept);
    if (sel) begin wr2 = 1'b1; data2 = b; end
    else     begin wr1 = 1'b1; data1 = b; end
    if (accept) sb.push_back(b);
    @(posedge clk); #1;
    wr1 = 1'b0;
    wr2 = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_of(sel) !== 1'b0 && n < 600) begin @(negedge clk); n++; end
    check("idle_timeout", busy_of(sel), 1'b0);
    @(posedge clk); #1;
  endtask

  // Samples one whole frame on the negative edge, decodes it mid-bit and checks its shape.
  task automatic rx_frame(input bit sel, input int nstop, input bit b2b);
    int         len, n, bad;
    logic       smp [48];
    logic [7:0] got;
    logic       ideal;
    len = (9 + nstop) * BD;
    @(negedge clk);
    n = 1;
    if (b2b) check("b2b_start", tx_of(sel), 1'b0);
    else begin
      while (tx_of(sel) !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      if (tx_of(sel) !== 1'b0) begin
        check("start_timeout", tx_of(sel), 1'b0);
        return;
      end
    end
    last_start = cyc;
    smp[0] = tx_of(sel);
    for (int i = 1; i < len; i++) begin @(negedge clk); smp[i] = tx_of(sel); end
    for (int k = 0; k < 8; k++) got[k] = smp[BD * (k + 1) + BD / 2];
    bad = 0;
    for (int i = 0; i < len; i++) begin
      if (i < BD)          ideal = 1'b0;
      else if (i < 9 * BD) ideal = got[(i - BD) / BD];
      else                 ideal = 1'b1;
      if (smp[i] !== ideal) bad++;
    end
    check("frame_shape", bad, 0);
    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) check("rx_byte", got, sb.pop_front());
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx1, 1'b1);
    check("rst_full", full1, 1'b0);
    check("rst_empty", empty1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_ovf", ovf1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single byte, latency and busy release
    t0 = cyc;
    wr_byte(0, 8'h55, 1);
    rx_frame(0, 1, 0);
    check("t1_latency", last_start - t0, 2);
    check("t1_busy_last", busy1, 1'b1);
    @(negedge clk);
    check("t1_busy_drop", busy1, 1'b0);
    check("t1_drop_cycle", cyc - t0, 42);
    @(posedge clk); #1;

    // 2: two consecutive writes give two contiguous frames
    t0 = cyc;
    fork
      begin
        wr_byte(0, 8'hA3, 1);
        wr_byte(0, 8'h0F, 1);
      end
      begin
        rx_frame(0, 1, 0);
        rx_frame(0, 1, 1);
      end
      begin
        wait_cyc(t0 + 41);
        @(negedge clk);
        check("t2_empty_before_pop", empty1, 1'b0);
        @(negedge clk);
        check("t2_empty_after_pop", empty1, 1'b1);
      end
    join
    wait_idle(0);

    // 3: overfill, overflow set and cleared, five bytes delivered in order
    fork
      begin
        for (int i = 0; i < 6; i++) wr_byte(0, t3[i], i < 5);
        check("t3_full", full1, 1'b1);
        check("t3_ovf_set", ovf1, 1'b1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("t3_ovf_clr", ovf1, 1'b0);
      end
      begin
        rx_frame(0, 1, 0);
        for (int i = 1; i < 5; i++) rx_frame(0, 1, 1);
      end
    join
    wait_idle(0);
    check("t3_empty_end", empty1, 1'b1);
    check("t3_sb_drained", sb.size(), 0);

    // 4: write while full in the same cycle as the STOP->START pop
    t0 = cyc;
    fork
      begin
        for (int i = 0; i < 5; i++) wr_byte(0, t4[i], 1);
        wait_cyc(t0 + 41);
        check("t4_full_before", full1, 1'b1);
        wr_byte(0, t4[5], 1);
        check("t4_ovf", ovf1, 1'b0);
        check("t4_full_after", full1, 1'b1);
      end
      begin
        rx_frame(0, 1, 0);
        for (int i = 1; i < 6; i++) rx_frame(0, 1, 1);
      end
    join
    wait_idle(0);
    check("t4_sb_drained", sb.size(), 0);

    // 5: two stop bits
    t0 = cyc;
    wr_byte(1, 8'hFF, 1);
    rx_frame(1, 2, 0);
    check("t5_latency", last_start - t0, 2);
    check("t5_busy_last", busy2, 1'b1);
    @(negedge clk);
    check("t5_busy_drop", busy2, 1'b0);
    check("t5_len", cyc - last_start, 44);
    check("t5_tx_idle", tx2, 1'b1);
    @(posedge clk); #1;

    // 6: asynchronous reset in the middle of the data bits
    t0 = cyc;
    wr_byte(0, 8'h3C, 0);
    wr_byte(0, 8'h99, 0);
    wait_cyc(t0 + 10);
    check("t6_pre_tx", tx1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_tx", tx1, 1'b1);
    check("t6_rst_empty", empty1, 1'b1);
    check("t6_rst_busy", busy1, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lows++;
    end
    check("t6_quiet", lows, 0);
    @(posedge clk); #1;
    t0 = cyc;
    wr_byte(0, 8'h81, 1);
    rx_frame(0, 1, 0);
    check("t6_latency", last_start - t0, 2);
    wait_idle(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
